wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_if.sv | 42 ++++
 rtl/wb_regfile.sv | 98 +++++++++
 tb/tb_wb_regfile.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Purpose: writeback / decode-read / forwarding signal bundle for wb_regfile.
// Latency: none, wires only.
// Backpressure: none; every signal is valid each cycle.
interface wb_regfile_if #(
    parameter int COUNT_W = 32
);
    // MEM/WB pipeline register contents
    logic [31:0]        ReadDataWbIn;
    logic [31:0]        ALUOutWbIn;
    logic               RegWriteWbIn;
    logic               MemToRegWbIn;
    logic [4:0]         WriteRegWbIn;
    // decode-stage read ports
    logic [4:0]         RegAddr1;
    logic [4:0]         RegAddr2;
    logic [31:0]        RegData1;
    logic [31:0]        RegData2;
    logic [31:0]        ResultWb;
    // EX operand forwarding
    logic [4:0]         ExRs1;
    logic [4:0]         ExRs2;
    logic [4:0]         MemRd;
    logic               MemRegWrite;
    logic [1:0]         ForwardA;
    logic [1:0]         ForwardB;
    // commit statistics
    logic [COUNT_W-1:0] RetireCount;

    // pipeline side: drives writeback, read addresses and hazard info
    modport master (
        output ReadDataWbIn, ALUOutWbIn, RegWriteWbIn, MemToRegWbIn, WriteRegWbIn,
        output RegAddr1, RegAddr2, ExRs1, ExRs2, MemRd, MemRegWrite,
        input  RegData1, RegData2, ResultWb, ForwardA, ForwardB, RetireCount
    );

    // register file side
    modport slave (
        input  ReadDataWbIn, ALUOutWbIn, RegWriteWbIn, MemToRegWbIn, WriteRegWbIn,
        input  RegAddr1, RegAddr2, ExRs1, ExRs2, MemRd, MemRegWrite,
        output RegData1, RegData2, ResultWb, ForwardA, ForwardB, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Purpose: 31x32 register file (x0 hardwired to 0) with writeback mux, write-through bypass, EX forwarding and retire counter.
// Latency: reads, ResultWb and forwarding are combinational; a commit lands in storage on the next posedge.
// Backpressure: none; a writeback is accepted every cycle.
module wb_regfile #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);

    logic [31:0]        regs [1:31];
    logic [COUNT_W-1:0] retire_cnt;
    logic               commit_vld;
    logic [31:0]        rd1_dat;
    logic [31:0]        rd2_dat;

    // Writeback value: load data or ALU result.
    assign bus.ResultWb = bus.MemToRegWbIn ? bus.ReadDataWbIn : bus.ALUOutWbIn;

    // A commit needs reset released, write enabled and a non-zero destination.
    // Gating on rst also kills the bypass while reset is held.
    assign commit_vld = rst & bus.RegWriteWbIn & (bus.WriteRegWbIn != 5'd0);

    // Forwarding select for one EX source: MEM stage wins over WB, 2'b11 never produced.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Forwarding is purely combinational on pipeline inputs and ignores reset.
    assign bus.ForwardA = fwd_sel(bus.ExRs1, bus.MemRd, bus.MemRegWrite,
                                  bus.WriteRegWbIn, bus.RegWriteWbIn);
    assign bus.ForwardB = fwd_sel(bus.ExRs2, bus.MemRd, bus.MemRegWrite,
                                  bus.WriteRegWbIn, bus.RegWriteWbIn);

    // Read port 1: x0 reads zero, same-cycle commit bypasses storage.
    always_comb begin
        rd1_dat = 32'd0;
        if (bus.RegAddr1 != 5'd0) begin
            if (commit_vld && (bus.WriteRegWbIn == bus.RegAddr1)) begin
                rd1_dat = bus.ResultWb;
            end else begin
                rd1_dat = regs[bus.RegAddr1];
            end
        end
    end

    // Read port 2: identical to port 1, bypasses independently.
    always_comb begin
        rd2_dat = 32'd0;
        if (bus.RegAddr2 != 5'd0) begin
            if (commit_vld && (bus.WriteRegWbIn == bus.RegAddr2)) begin
                rd2_dat = bus.ResultWb;
            end else begin
                rd2_dat = regs[bus.RegAddr2];
            end
        end
    end

    assign bus.RegData1 = rd1_dat;
    assign bus.RegData2 = rd2_dat;

    // Storage: async clear of x1..x31, commit writes the selected result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (commit_vld) begin
            regs[bus.WriteRegWbIn] <= bus.ResultWb;
        end
    end

    // Retire counter: one per commit, wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (commit_vld) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign bus.RetireCount = retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Purpose: self-checking bench for wb_regfile using a reference model and an expectation queue.
// Latency: expectations are compared combinationally mid low-phase; model commits on posedge.
// Backpressure: n/a.
module tb_wb_regfile;

    localparam int CW = 4;

    localparam logic [2:0] K_RD1 = 3'd0;
    localparam logic [2:0] K_RD2 = 3'd1;
    localparam logic [2:0] K_RES = 3'd2;
    localparam logic [2:0] K_FWA = 3'd3;
    localparam logic [2:0] K_FWB = 3'd4;
    localparam logic [2:0] K_CNT = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] exp;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail = 0;
    sb_item_t    sb_q[$];
    string       tag_q[$];
    logic [31:0] model_regs [0:31];
    int          model_cnt;

    wb_regfile_if #(.COUNT_W(CW)) bif();

    wb_regfile #(.COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [2:0] kind, input logic [31:0] exp);
        sb_item_t it;
        it.kind = kind;
        it.exp  = exp;
        sb_q.push_back(it);
        tag_q.push_back(tag);
    endtask

    // Compare every queued expectation against the matching DUT output.
    task automatic sb_drain();
        sb_item_t    it;
        string       tag;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            tag = tag_q.pop_front();
            case (it.kind)
                K_RD1:   obs = bif.RegData1;
                K_RD2:   obs = bif.RegData2;
                K_RES:   obs = bif.ResultWb;
                K_FWA:   obs = {30'd0, bif.ForwardA};
                K_FWB:   obs = {30'd0, bif.ForwardB};
                default: obs = 32'(bif.RetireCount);
            endcase
            check_val(tag, obs, it.exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_result();
        return bif.MemToRegWbIn ? bif.ReadDataWbIn : bif.ALUOutWbIn;
    endfunction

    function automatic logic m_commit();
        return rst && bif.RegWriteWbIn && (bif.WriteRegWbIn != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_commit() && bif.WriteRegWbIn == a) return m_result();
        return model_regs[a];
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (bif.MemRegWrite && bif.MemRd != 5'd0 && bif.MemRd == rs) return 2'b10;
        if (bif.RegWriteWbIn && bif.WriteRegWbIn != 5'd0 && bif.WriteRegWbIn == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_cnt();
        return 32'(model_cnt % (1 << CW));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_cnt = 0;
    endtask

    // Advance through a posedge, mirroring any commit, and return to the low phase.
    task automatic commit_edge();
        @(posedge clk);
        if (m_commit()) begin
            model_regs[bif.WriteRegWbIn] = m_result();
            model_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic push_all(input string pfx);
        sb_push({pfx, "_rd1"}, K_RD1, m_read(bif.RegAddr1));
        sb_push({pfx, "_rd2"}, K_RD2, m_read(bif.RegAddr2));
        sb_push({pfx, "_res"}, K_RES, m_result());
        sb_push({pfx, "_fwa"}, K_FWA, {30'd0, m_fwd(bif.ExRs1)});
        sb_push({pfx, "_fwb"}, K_FWB, {30'd0, m_fwd(bif.ExRs2)});
    endtask

    task automatic drive_idle();
        bif.ReadDataWbIn = 32'd0;
        bif.ALUOutWbIn   = 32'd0;
        bif.RegWriteWbIn = 1'b0;
        bif.MemToRegWbIn = 1'b0;
        bif.WriteRegWbIn = 5'd0;
        bif.RegAddr1     = 5'd0;
        bif.RegAddr2     = 5'd0;
        bif.ExRs1        = 5'd0;
        bif.ExRs2        = 5'd0;
        bif.MemRd        = 5'd0;
        bif.MemRegWrite  = 1'b0;
    endtask

    task automatic drive_write(input logic [4:0] rd, input logic mem2reg,
                               input logic [31:0] alu, input logic [31:0] ld);
        bif.RegWriteWbIn = 1'b1;
        bif.WriteRegWbIn = rd;
        bif.MemToRegWbIn = mem2reg;
        bif.ALUOutWbIn   = alu;
        bif.ReadDataWbIn = ld;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        #12;
        sb_push("rst_low_cnt", K_CNT, 32'd0);
        sb_drain();

        // Reset state: every address on both ports reads zero.
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bif.RegAddr1 = 5'(a);
            bif.RegAddr2 = 5'(31 - a);
            #1;
            sb_push($sformatf("reset_rd1_a%0d", a), K_RD1, 32'd0);
            sb_push($sformatf("reset_rd2_a%0d", a), K_RD2, 32'd0);
            sb_drain();
            @(negedge clk);
        end
        sb_push("reset_cnt", K_CNT, 32'd0);
        sb_drain();

        // ALU writeback to x5 with same-cycle read bypass.
        drive_write(5'd5, 1'b0, 32'h1234_5678, 32'h0);
        bif.RegAddr1 = 5'd5;
        bif.RegAddr2 = 5'd6;
        #1;
        sb_push("byp_rd1", K_RD1, 32'h1234_5678);
        sb_push("byp_rd2", K_RD2, 32'd0);
        sb_push("byp_res", K_RES, 32'h1234_5678);
        sb_drain();
        commit_edge();
        bif.RegWriteWbIn = 1'b0;
        #1;
        sb_push("x5_stored", K_RD1, 32'h1234_5678);
        sb_push("cnt_after_x5", K_CNT, 32'd1);
        sb_drain();

        // Load writeback to x0: no state change, no count.
        drive_write(5'd0, 1'b1, 32'h5555_0000, 32'hDEAD_BEEF);
        bif.RegAddr1 = 5'd0;
        #1;
        sb_push("x0_rd1", K_RD1, 32'd0);
        sb_push("x0_res", K_RES, 32'hDEAD_BEEF);
        sb_drain();
        commit_edge();
        sb_push("x0_cnt", K_CNT, 32'd1);
        sb_drain();

        // Both ports bypass the same register.
        drive_write(5'd9, 1'b1, 32'h0, 32'hCAFE_0009);
        bif.RegAddr1 = 5'd9;
        bif.RegAddr2 = 5'd9;
        #1;
        sb_push("dual_byp_rd1", K_RD1, 32'hCAFE_0009);
        sb_push("dual_byp_rd2", K_RD2, 32'hCAFE_0009);
        sb_drain();
        commit_edge();
        bif.RegWriteWbIn = 1'b0;

        // Forwarding priority and x0 exclusion.
        bif.ExRs1 = 5'd7;
        bif.ExRs2 = 5'd3;
        bif.MemRd = 5'd7;
        bif.MemRegWrite = 1'b1;
        bif.WriteRegWbIn = 5'd7;
        bif.RegWriteWbIn = 1'b1;
        #1;
        sb_push("fwd_mem_pri", K_FWA, 32'd2);
        sb_push("fwd_b_none", K_FWB, 32'd0);
        sb_drain();
        bif.MemRegWrite = 1'b0;
        #1;
        sb_push("fwd_wb", K_FWA, 32'd1);
        sb_drain();
        bif.ExRs2 = 5'd0;
        bif.MemRd = 5'd0;
        bif.WriteRegWbIn = 5'd0;
        bif.MemRegWrite = 1'b1;
        #1;
        sb_push("fwd_x0", K_FWB, 32'd0);
        sb_drain();
        commit_edge();
        drive_idle();

        // Randomised traffic against the model.
        for (int i = 0; i < 60; i++) begin
            bif.RegWriteWbIn = 1'($urandom_range(0, 1));
            bif.MemToRegWbIn = 1'($urandom_range(0, 1));
            bif.ReadDataWbIn = $urandom;
            bif.ALUOutWbIn   = $urandom;
            bif.WriteRegWbIn = 5'($urandom_range(0, 31));
            bif.RegAddr1     = ($urandom_range(0, 3) == 0) ? bif.WriteRegWbIn : 5'($urandom_range(0, 31));
            bif.RegAddr2     = ($urandom_range(0, 3) == 0) ? bif.WriteRegWbIn : 5'($urandom_range(0, 31));
            bif.MemRd        = 5'($urandom_range(0, 7));
            bif.MemRegWrite  = 1'($urandom_range(0, 1));
            bif.ExRs1        = ($urandom_range(0, 1) == 0) ? bif.MemRd : bif.WriteRegWbIn;
            bif.ExRs2        = 5'($urandom_range(0, 7));
            #1;
            push_all("rnd");
            sb_drain();
            commit_edge();
        end
        drive_idle();
        #1;
        sb_push("rnd_cnt", K_CNT, m_cnt());
        sb_drain();

        // Mid-operation reset: x3 cleared at once, in-flight write to x4 dropped.
        drive_write(5'd3, 1'b0, 32'hA5A5_A5A5, 32'h0);
        commit_edge();
        bif.RegWriteWbIn = 1'b0;
        bif.RegAddr1 = 5'd3;
        #1;
        sb_push("x3_before_rst", K_RD1, 32'hA5A5_A5A5);
        sb_drain();
        #1;
        rst = 1'b0;
        model_reset();
        drive_write(5'd4, 1'b0, 32'h0BAD_F00D, 32'h0);
        bif.RegAddr2 = 5'd4;
        bif.ExRs1 = 5'd4;
        bif.MemRegWrite = 1'b0;
        #1;
        sb_push("rst_x3", K_RD1, 32'd0);
        sb_push("rst_nobyp", K_RD2, 32'd0);
        sb_push("rst_cnt", K_CNT, 32'd0);
        sb_push("rst_fwd", K_FWA, 32'd1);
        sb_drain();
        commit_edge();
        sb_push("rst_held_x4", K_RD2, 32'd0);
        sb_drain();

        // First commit lands on the first posedge after release.
        rst = 1'b1;
        #1;
        sb_push("rel_byp_x4", K_RD2, 32'h0BAD_F00D);
        sb_drain();
        commit_edge();
        bif.RegWriteWbIn = 1'b0;
        #1;
        sb_push("rel_x4", K_RD2, 32'h0BAD_F00D);
        sb_push("rel_cnt", K_CNT, 32'd1);
        sb_drain();

        // Counter wrap: 16 commits from zero with a 4-bit counter.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            drive_write(5'(i % 31 + 1), 1'b0, 32'(i), 32'h0);
            #1;
            sb_push($sformatf("wrap_cnt_%0d", i), K_CNT, m_cnt());
            sb_drain();
            commit_edge();
        end
        bif.RegWriteWbIn = 1'b0;
        #1;
        sb_push("wrap_zero", K_CNT, 32'd0);
        sb_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
